// File: rtl/chiplib_riscv_plic_pkg.sv
// Shared types and constants for the PLIC interrupt gateway.
package chiplib_riscv_plic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLAIMED = 2'd2
  } gw_state_e;

  // Interrupt ID 0 means "no interrupt" and never pends.
  localparam int GW_ID_RESERVED = 32'sd0;

endpackage

// File: rtl/chiplib_riscv_plic_gateway_src.sv
// One gateway source: input synchroniser, edge history, saturating edge
// counter and the IDLE/PENDING/CLAIMED claim-complete state machine.
module chiplib_riscv_plic_gateway_src
  import chiplib_riscv_plic_pkg::*;
#(
  parameter bit IsEdge       = 1'b0,
  parameter int SyncStages   = 2,
  parameter int EdgeCntWidth = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_raw,
  input  logic claim_hit,
  input  logic complete_hit,
  output logic pend,
  output logic claimed
);

  localparam logic [EdgeCntWidth-1:0] CntZero = {EdgeCntWidth{1'b0}};
  localparam logic [EdgeCntWidth-1:0] CntMax  = {EdgeCntWidth{1'b1}};
  localparam logic [EdgeCntWidth-1:0] CntOne  = EdgeCntWidth'(1'b1);

  logic                    sync_s;
  logic                    prev_r;
  logic                    edge_s;
  logic                    pend_r;
  logic                    claimed_r;
  logic [EdgeCntWidth-1:0] cnt_r;
  logic [EdgeCntWidth-1:0] cnt_nxt_s;
  gw_state_e               state_r;
  gw_state_e               state_nxt_s;

  if (SyncStages > 0) begin : g_sync
    logic [SyncStages-1:0] sync_r;

    // Synchroniser chain for the asynchronous device line.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_r <= {SyncStages{1'b0}};
      end else begin
        sync_r[0] <= irq_raw;
        for (int k = 1; k < SyncStages; k++) begin
          sync_r[k] <= sync_r[k-1];
        end
      end
    end

    assign sync_s = sync_r[SyncStages-1];
  end else begin : g_nosync
    assign sync_s = irq_raw;
  end

  assign edge_s = sync_s & ~prev_r;

  // Next-state and edge-count logic; a queued edge pays for leaving IDLE.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (IsEdge && (cnt_r != CntZero)) begin
          state_nxt_s = PENDING;
          cnt_nxt_s   = cnt_r - CntOne + (edge_s ? CntOne : CntZero);
        end else if (IsEdge ? edge_s : sync_s) begin
          state_nxt_s = PENDING;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PENDING, CLAIMED: begin
        if (state_r == PENDING) begin
          state_nxt_s = claim_hit ? CLAIMED : PENDING;
        end else begin
          state_nxt_s = complete_hit ? IDLE : CLAIMED;
        end
        if (IsEdge && edge_s && (cnt_r != CntMax)) begin
          cnt_nxt_s = cnt_r + CntOne;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CntZero;
      end
    endcase
  end

  // State, edge history, counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= CntZero;
      prev_r    <= 1'b0;
      pend_r    <= 1'b0;
      claimed_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      prev_r    <= sync_s;
      pend_r    <= (state_nxt_s == PENDING);
      claimed_r <= (state_nxt_s == CLAIMED);
    end
  end

  assign pend    = pend_r;
  assign claimed = claimed_r;

endmodule

// File: rtl/chiplib_riscv_plic_gateway.sv
// PLIC gateway top: decodes the merged claim/complete buses into per-source
// hits and instantiates one gateway per non-reserved interrupt ID.
module chiplib_riscv_plic_gateway
  import chiplib_riscv_plic_pkg::*;
#(
  parameter int                    NumSources   = 100,
  parameter logic [NumSources-1:0] EdgeMask     = {NumSources{1'b0}},
  parameter int                    SyncStages   = 2,
  parameter int                    EdgeCntWidth = 3,
  localparam int                   IdWidth      = $clog2(NumSources)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NumSources-1:0] irq_src,
  input  logic                  claim_valid,
  input  logic [IdWidth-1:0]    claim_id,
  input  logic                  complete_valid,
  input  logic [IdWidth-1:0]    complete_id,
  output logic [NumSources-1:0] irq_pend,
  output logic [NumSources-1:0] irq_claimed
);

  localparam int FirstId = GW_ID_RESERVED + 1;

  logic [NumSources-1:FirstId] claim_hit_s;
  logic [NumSources-1:FirstId] complete_hit_s;
  logic                        unused_s;

  // One-hot decode; IDs at or beyond NumSources match nothing.
  always_comb begin
    claim_hit_s    = {(NumSources-FirstId){1'b0}};
    complete_hit_s = {(NumSources-FirstId){1'b0}};
    for (int i = FirstId; i < NumSources; i++) begin
      claim_hit_s[i]    = claim_valid && (claim_id == IdWidth'(i));
      complete_hit_s[i] = complete_valid && (complete_id == IdWidth'(i));
    end
  end

  for (genvar g = FirstId; g < NumSources; g++) begin : g_src
    chiplib_riscv_plic_gateway_src #(
      .IsEdge      (EdgeMask[g]),
      .SyncStages  (SyncStages),
      .EdgeCntWidth(EdgeCntWidth)
    ) u_src (
      .clk         (clk),
      .rst         (rst),
      .irq_raw     (irq_src[g]),
      .claim_hit   (claim_hit_s[g]),
      .complete_hit(complete_hit_s[g]),
      .pend        (irq_pend[g]),
      .claimed     (irq_claimed[g])
    );
  end

  // The reserved ID is permanently idle.
  assign irq_pend[GW_ID_RESERVED]    = 1'b0;
  assign irq_claimed[GW_ID_RESERVED] = 1'b0;
  assign unused_s                    = irq_src[GW_ID_RESERVED];

endmodule
